// File: rtl/acq_pkg.sv
// Acquisition controller shared definitions: FSM state encoding and default sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package acq_pkg;

  // Default channel count, sized to the 8-bit channel enable register.
  localparam int ACQ_NUM_CH = 8;
  // Default sample counter width, sized to the 32-bit sample count register.
  localparam int ACQ_CNT_W  = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } acq_state_e;

endpackage : acq_pkg

// File: rtl/acq_ch_scan.sv
// Channel scanner: finds the next enabled channel strictly above cur_ch_i.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is valid whenever the inputs are.
//
// Ports:
//   mask_i    channel enable mask, bit i = channel i
//   cur_ch_i  current channel
//   nxt_ch_o  lowest enabled channel above cur_ch_i (0 when there is none)
//   last_o    1 when no enabled channel exists above cur_ch_i
module acq_ch_scan #(
  parameter int NUM_CH = 8,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] mask_i,
  input  logic [CH_W-1:0]   cur_ch_i,
  output logic [CH_W-1:0]   nxt_ch_o,
  output logic              last_o
);

  always_comb begin
    nxt_ch_o = '0;
    last_o   = 1'b1;
    // Walk downward so the last hit kept is the lowest enabled channel above cur.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_i[i] && (i > int'(cur_ch_i))) begin
        nxt_ch_o = CH_W'(i);
        last_o   = 1'b0;
      end
    end
  end

endmodule : acq_ch_scan

// File: rtl/acq_ctrl.sv
// Acquisition controller: on a trigger rising edge, issues data_number sample
// requests for every enabled channel, channel by channel in ascending order.
// Latency: first request one cycle after the start cycle, then one beat per
// accepted cycle. Backpressure: smp_ch/smp_idx hold while smp_valid && !smp_ready.
//
// Optional feature: define ACQ_TIMESTAMP_EN to add run_ts, the value of a
// free-running 32-bit cycle counter captured on each start cycle.
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   data_number   samples per enabled channel (latched on start)
//   channel_ctrl  channel enable mask (latched on start)
//   trigger_cmd   run level: rising edge starts, low during a run aborts
//   smp_valid/smp_ready, smp_ch, smp_idx   sample request handshake
//   busy          run in progress (start through done/abort)
//   done          one-cycle pulse on normal completion
//   aborted       one-cycle pulse on abort
//   run_ts        start timestamp (ACQ_TIMESTAMP_EN only)
module acq_ctrl
  import acq_pkg::*;
#(
  parameter int NUM_CH = ACQ_NUM_CH,
  parameter int CNT_W  = ACQ_CNT_W,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CNT_W-1:0]  data_number,
  input  logic [NUM_CH-1:0] channel_ctrl,
  input  logic              trigger_cmd,
  output logic              smp_valid,
  input  logic              smp_ready,
  output logic [CH_W-1:0]   smp_ch,
  output logic [CNT_W-1:0]  smp_idx,
  output logic              busy,
  output logic              done,
  output logic              aborted
`ifdef ACQ_TIMESTAMP_EN
  ,
  output logic [31:0]       run_ts
`endif
);

  acq_state_e        state_q, state_d;
  logic              trig_q;
  logic              armed_q, armed_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]  cnt_m1_q, cnt_m1_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              aborted_q, aborted_d;

  logic              start;
  logic              idx_last;
  logic [CH_W-1:0]   scan_nxt_ch;
  logic              scan_last;
  logic [CH_W-1:0]   first_scan_ch;
  logic              first_scan_last;
  logic [CH_W-1:0]   first_ch;
  logic              mask_empty;

  // Next enabled channel after the one currently being sampled (latched mask).
  acq_ch_scan #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_scan_nxt (
    .mask_i   (mask_q),
    .cur_ch_i (ch_q),
    .nxt_ch_o (scan_nxt_ch),
    .last_o   (scan_last)
  );

  // Lowest enabled channel of the incoming mask: channel 0 itself, or the
  // first one above channel 0.
  acq_ch_scan #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_scan_first (
    .mask_i   (channel_ctrl),
    .cur_ch_i ('0),
    .nxt_ch_o (first_scan_ch),
    .last_o   (first_scan_last)
  );

  assign first_ch   = channel_ctrl[0] ? '0 : first_scan_ch;
  assign mask_empty = !channel_ctrl[0] && first_scan_last;

  // armed_q keeps a trigger that is already high when reset releases from
  // starting a run; trigger must be seen low once before an edge counts.
  assign start    = (state_q == IDLE) && trigger_cmd && !trig_q && armed_q;
  // Full-width compare against count-1, so the maximum count never wraps.
  assign idx_last = (idx_q == cnt_m1_q);
  assign armed_d  = armed_q | !trigger_cmd;

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    cnt_m1_d  = cnt_m1_q;
    ch_d      = ch_q;
    idx_d     = idx_q;
    aborted_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mask_d   = channel_ctrl;
          cnt_m1_d = data_number - CNT_W'(1);
          ch_d     = first_ch;
          idx_d    = '0;
          if ((data_number == '0) || mask_empty) begin
            state_d = FINISH;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        // Abort wins over completion; a beat accepted this cycle is still delivered.
        if (!trigger_cmd) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
          ch_d      = '0;
          idx_d     = '0;
        end else if (smp_ready) begin
          if (idx_last && scan_last) begin
            state_d = FINISH;
          end else if (idx_last) begin
            ch_d  = scan_nxt_ch;
            idx_d = '0;
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
        ch_d    = '0;
        idx_d   = '0;
      end

      default: begin
        state_d = IDLE;
        ch_d    = '0;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      trig_q    <= 1'b0;
      armed_q   <= 1'b0;
      mask_q    <= '0;
      cnt_m1_q  <= '0;
      ch_q      <= '0;
      idx_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      trig_q    <= trigger_cmd;
      armed_q   <= armed_d;
      mask_q    <= mask_d;
      cnt_m1_q  <= cnt_m1_d;
      ch_q      <= ch_d;
      idx_q     <= idx_d;
      aborted_q <= aborted_d;
    end
  end

  assign smp_valid = (state_q == RUN);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == FINISH);
  assign aborted   = aborted_q;
  assign smp_ch    = ch_q;
  assign smp_idx   = idx_q;

`ifdef ACQ_TIMESTAMP_EN
  logic [31:0] ts_cnt_q;
  logic [31:0] run_ts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_cnt_q <= '0;
      run_ts_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 32'd1;
      if (start) begin
        run_ts_q <= ts_cnt_q;
      end
    end
  end

  assign run_ts = run_ts_q;
`endif

endmodule : acq_ctrl

// File: tb/tb_acq_ctrl.sv
// Self-checking bench for acq_ctrl: directed and randomized runs checked
// against an expected beat list built from the channel mask and sample count.
// Also covers abort, mid-run input changes, max count and reset mid-run.
module tb_acq_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] data_number;
  logic [7:0]  channel_ctrl;
  logic        trigger_cmd;
  logic        smp_valid;
  logic        smp_ready;
  logic [2:0]  smp_ch;
  logic [31:0] smp_idx;
  logic        busy;
  logic        done;
  logic        aborted;
`ifdef ACQ_TIMESTAMP_EN
  logic [31:0] run_ts;
  logic [31:0] tb_ts;
`endif

  int n_cmp = 0;
  int n_err = 0;

  acq_ctrl #(
    .NUM_CH (8),
    .CNT_W  (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_number  (data_number),
    .channel_ctrl (channel_ctrl),
    .trigger_cmd  (trigger_cmd),
    .smp_valid    (smp_valid),
    .smp_ready    (smp_ready),
    .smp_ch       (smp_ch),
    .smp_idx      (smp_idx),
    .busy         (busy),
    .done         (done),
    .aborted      (aborted)
`ifdef ACQ_TIMESTAMP_EN
    ,
    .run_ts       (run_ts)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ACQ_TIMESTAMP_EN
  // Reference cycle count: edges seen since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_ts <= '0;
    else        tb_ts <= tb_ts + 32'd1;
  end
`endif

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete run. mode: 0 ready always high, 1 ready every other cycle,
  // 2 random ready. abort_at >= 0 drops trigger together with that accepted beat.
  task automatic run_case(input string tag, input logic [31:0] n, input logic [7:0] m,
                          input int mode, input int abort_at, input bit mutate);
    int unsigned exp_ch[$];
    logic [31:0] exp_idx[$];
    int          acc, dones, aborts, total, cyc;
    bit          ended, exp_done_next, exp_abort_next, exp_idle_next, stalled;
    logic [2:0]  pch;
    logic [31:0] pidx;
`ifdef ACQ_TIMESTAMP_EN
    logic [31:0] ts0;
`endif

    for (int c = 0; c < 8; c++) begin
      if (m[c]) begin
        for (longint unsigned i = 0; (i < 64'(n)) && (i < 256); i++) begin
          exp_ch.push_back(c);
          exp_idx.push_back(32'(i));
        end
      end
    end
    total = (abort_at >= 0) ? abort_at : exp_ch.size();

    data_number  = n;
    channel_ctrl = m;
    smp_ready    = 1'b0;
    trigger_cmd  = 1'b0;
    step();
    step();
    trigger_cmd = 1'b1;
`ifdef ACQ_TIMESTAMP_EN
    ts0 = tb_ts;
`endif

    acc = 0; dones = 0; aborts = 0;
    ended = 0; exp_abort_next = 0; exp_idle_next = 0; stalled = 0;
    exp_done_next = (exp_ch.size() == 0);
    pch = '0; pidx = '0;
    cyc = 0;

    while (!ended && cyc < 3000) begin
      step();
      if (cyc == 0) check({tag, ":first_valid"}, 64'(smp_valid), 64'(exp_ch.size() != 0));
      if (mutate && cyc == 1) begin
        data_number  = 32'd9;
        channel_ctrl = 8'hFF;
      end
      if (done)    dones++;
      if (aborted) aborts++;

      if (exp_done_next) begin
        check({tag, ":done_pulse"}, 64'(done), 64'(1));
        check({tag, ":valid_after_last"}, 64'(smp_valid), 64'(0));
        check({tag, ":busy_in_done"}, 64'(busy), 64'(1));
        exp_done_next = 0;
        exp_idle_next = 1;
      end else if (exp_abort_next) begin
        check({tag, ":aborted_pulse"}, 64'(aborted), 64'(1));
        check({tag, ":valid_after_abort"}, 64'(smp_valid), 64'(0));
        check({tag, ":busy_after_abort"}, 64'(busy), 64'(0));
        ended = 1;
      end else if (exp_idle_next) begin
        check({tag, ":busy_after_done"}, 64'(busy), 64'(0));
        ended = 1;
      end else begin
        if (stalled) begin
          check({tag, ":stall_ch"}, 64'(smp_ch), 64'(pch));
          check({tag, ":stall_idx"}, 64'(smp_idx), 64'(pidx));
        end
        if (mode == 0) check({tag, ":gapless"}, 64'(smp_valid), 64'(1));
      end

      case (mode)
        0:       smp_ready = 1'b1;
        1:       smp_ready = ((cyc % 2) == 1);
        default: smp_ready = 1'($urandom_range(0, 1));
      endcase
      stalled = smp_valid && !smp_ready;
      pch     = smp_ch;
      pidx    = smp_idx;

      if (smp_valid && smp_ready) begin
        if (acc < exp_ch.size()) begin
          check({tag, ":beat_ch"}, 64'(smp_ch), 64'(exp_ch[acc]));
          check({tag, ":beat_idx"}, 64'(smp_idx), 64'(exp_idx[acc]));
        end else begin
          check({tag, ":extra_beat"}, 64'(1), 64'(0));
        end
        acc++;
        if (abort_at >= 0 && acc == abort_at) begin
          trigger_cmd    = 1'b0;
          exp_abort_next = 1;
        end else if (abort_at < 0 && acc == exp_ch.size()) begin
          exp_done_next = 1;
        end
      end
      cyc++;
    end
    if (!ended) check({tag, ":timeout"}, 64'(0), 64'(1));

    // Quiet tail: nothing more may happen until the next trigger edge.
    smp_ready = 1'b1;
    repeat (3) begin
      step();
      if (done)      dones++;
      if (aborted)   aborts++;
      if (smp_valid) acc++;
    end
    check({tag, ":beats"}, 64'(acc), 64'(total));
    check({tag, ":done_count"}, 64'(dones), 64'((abort_at >= 0) ? 0 : 1));
    check({tag, ":abort_count"}, 64'(aborts), 64'((abort_at >= 0) ? 1 : 0));
`ifdef ACQ_TIMESTAMP_EN
    check({tag, ":run_ts"}, 64'(run_ts), 64'(ts0));
`endif
  endtask

  initial begin
    rst_n        = 1'b0;
    data_number  = '0;
    channel_ctrl = '0;
    trigger_cmd  = 1'b0;
    smp_ready    = 1'b0;
    #12;
    check("rst:valid", 64'(smp_valid), 64'(0));
    check("rst:busy", 64'(busy), 64'(0));
    check("rst:done", 64'(done), 64'(0));
    check("rst:aborted", 64'(aborted), 64'(0));
    check("rst:ch", 64'(smp_ch), 64'(0));
    check("rst:idx", 64'(smp_idx), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();

    run_case("basic",    32'd3,   8'b0000_0101, 0, -1, 0);
    run_case("toggle",   32'd3,   8'b0000_0101, 1, -1, 0);
    run_case("zero_n",   32'd0,   8'hFF,        0, -1, 0);
    run_case("zero_m",   32'd5,   8'h00,        0, -1, 0);
    run_case("abort",    32'd100, 8'h80,        0, 10, 0);
    run_case("mutate",   32'd4,   8'h01,        0, -1, 1);
    run_case("max_n",    32'hFFFF_FFFF, 8'h01,  0, 20, 0);
    run_case("one_top",  32'd1,   8'h80,        2, -1, 0);
    run_case("all_ch",   32'd2,   8'hFF,        2, -1, 0);

    for (int r = 0; r < 8; r++) begin
      logic [31:0] rn;
      logic [7:0]  rm;
      int          cnt, ab;
      rn  = 32'($urandom_range(0, 5));
      rm  = 8'($urandom_range(0, 255));
      cnt = 0;
      for (int c = 0; c < 8; c++) if (rm[c]) cnt += int'(rn);
      ab  = ((r % 2) == 1 && cnt > 2) ? int'($urandom_range(1, cnt - 1)) : -1;
      run_case($sformatf("rand%0d", r), rn, rm, 2, ab, 0);
    end

    // Reset mid-run with trigger held high through release.
    data_number  = 32'd20;
    channel_ctrl = 8'h03;
    smp_ready    = 1'b1;
    trigger_cmd  = 1'b0;
    step();
    step();
    trigger_cmd = 1'b1;
    repeat (5) step();
    check("midrst:running", 64'(smp_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("midrst:valid", 64'(smp_valid), 64'(0));
    check("midrst:busy", 64'(busy), 64'(0));
    check("midrst:ch", 64'(smp_ch), 64'(0));
    check("midrst:idx", 64'(smp_idx), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("midrst:no_start", 64'({smp_valid, busy, done, aborted}), 64'(0));
    end
    trigger_cmd = 1'b0;
    step();
    trigger_cmd = 1'b1;
    begin
`ifdef ACQ_TIMESTAMP_EN
      logic [31:0] ts_exp;
      ts_exp = tb_ts;
`endif
      step();
      check("rearm:valid", 64'(smp_valid), 64'(1));
      check("rearm:ch", 64'(smp_ch), 64'(0));
      check("rearm:idx", 64'(smp_idx), 64'(0));
`ifdef ACQ_TIMESTAMP_EN
      check("rearm:run_ts", 64'(run_ts), 64'(ts_exp));
`endif
    end
    trigger_cmd = 1'b0;
    step();
    check("rearm:aborted", 64'(aborted), 64'(1));
    check("rearm:busy", 64'(busy), 64'(0));
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_acq_ctrl

// File: doc/acq_ctrl.md
ACQ_CTRL -- requirements
Module: acq_ctrl

Interface
REQ-001 Parameter NUM_CH, default 8, number of channels (matches the 8-bit channel_ctrl register).
REQ-002 Parameter CNT_W, default 32, width of the sample counter (matches the 32-bit data_number register).
REQ-003 clk  input  1  sole clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 data_number  input  CNT_W  samples per enabled channel.
REQ-006 channel_ctrl  input  NUM_CH  channel enable mask, bit i = channel i.
REQ-007 trigger_cmd  input  1  run command level; rising edge starts a run, low during a run aborts it.
REQ-008 smp_valid  output  1  sample request valid.
REQ-009 smp_ready  input  1  downstream accepts the request.
REQ-010 smp_ch  output  $clog2(NUM_CH)  channel of the current request.
REQ-011 smp_idx  output  CNT_W  sample index within the channel, 0-based.
REQ-012 busy  output  1  high from run start until done or abort.
REQ-013 done  output  1  one-cycle pulse on normal completion.
REQ-014 aborted  output  1  one-cycle pulse on abort.

Function
REQ-015 The FSM SHALL have states IDLE, RUN, FINISH; transitions IDLE->RUN on start, RUN->FINISH after the last accepted beat, RUN->IDLE on abort, FINISH->IDLE unconditionally.
REQ-016 Start SHALL be detected when trigger_cmd=1 and its registered copy=0 while in IDLE; a rising edge in RUN or FINISH SHALL be ignored.
REQ-017 On start the block SHALL latch data_number and channel_ctrl; later changes to either SHALL have no effect until the next run.
REQ-018 smp_valid SHALL assert on the clock edge after start (latency 1) with smp_ch = lowest enabled channel and smp_idx = 0.
REQ-019 A beat is accepted when smp_valid && smp_ready; smp_ch and smp_idx SHALL stay stable while smp_valid && !smp_ready.
REQ-020 Order SHALL be all indices 0..N-1 of one channel, then the next higher enabled channel; disabled channels SHALL be skipped with no idle cycle.
REQ-021 With smp_ready held high, one beat SHALL be accepted per cycle.
REQ-022 After the last beat is accepted, smp_valid SHALL drop on the next edge, the FSM SHALL enter FINISH, and done SHALL pulse for that one cycle; busy SHALL drop on the following edge.
REQ-023 If the latched data_number is 0 or the latched mask is 0, the FSM SHALL go IDLE->FINISH directly, with no beats and done pulsed once.
REQ-024 trigger_cmd=0 sampled in RUN SHALL cause abort: on the next edge smp_valid=0, busy=0, aborted pulses for one cycle, and the FSM enters IDLE; a beat accepted in the abort cycle counts.
REQ-025 The counter SHALL compare against the latched count minus 1 at full CNT_W width with no overflow; data_number = 2^CNT_W-1 SHALL be supported.

Reset
REQ-026 Reset SHALL force state IDLE and drive smp_valid, busy, done, aborted, smp_ch, smp_idx and the trigger edge register to 0.
REQ-027 Reset asserted mid-run SHALL abandon the run with no done or aborted pulse; trigger_cmd already high at reset release SHALL NOT start a run.

Configuration
REQ-028 When ACQ_TIMESTAMP_EN is defined, an output run_ts[31:0] SHALL capture a free-running 32-bit cycle counter (reset 0, wraps) on the start cycle and hold it until the next start; when the macro is undefined, the port and the counter SHALL be absent.

Structure
REQ-029 Package acq_pkg SHALL hold the state enum (IDLE, RUN, FINISH) and the NUM_CH and CNT_W default constants.
REQ-030 Sub-module acq_ch_scan SHALL be combinational: given a mask and a current channel, it returns the next higher enabled channel and a last flag.

Verification
REQ-031 Test: data_number=3, mask=8'b0000_0101, ready=1, then raise trigger -> 6 beats (ch0 idx0-2, ch2 idx0-2) on consecutive cycles, then one done pulse.
REQ-032 Test: same run with ready toggling every other cycle -> same 6 beats, ch and idx stable while stalled.
REQ-033 Test: data_number=0 with mask=8'hFF, then mask=0 with data_number=5 -> no beats, exactly one done each run.
REQ-034 Test: data_number=100, mask=8'h80, drop trigger after 10 accepted beats -> smp_valid low on the next edge, one aborted pulse, no done.
REQ-035 Test: change data_number and mask in the middle of a run (4 to 9, mask 8'h01 to 8'hFF) -> run still completes with 4 beats on ch0 only.
REQ-036 Test: assert rst_n low in the middle of a run, with trigger held high through release -> all outputs 0 and no new run until trigger goes low then high again; with ACQ_TIMESTAMP_EN defined, run_ts equals the counter value on the start cycle.
